// File: rtl/axi4_sram_pkg.sv
// Shared encodings for the AXI4-to-SRAM slave: burst types, response codes and FSM states.
package axi4_sram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_REQ,
    RD_RESP
  } state_t;

endpackage

// File: rtl/axi_burst_addr_next.sv
// Next beat address for AXI FIXED/INCR/WRAP bursts; reserved burst code behaves as INCR.
module axi_burst_addr_next
  import axi4_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_WIDTH'(1) << size;
    incr      = addr + step;
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:     next_addr = incr;
    endcase
  end

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 slave serving one read or write burst at a time from a single-port synchronous SRAM.
// Define AXI_SRAM_BOUNDS_CHK_EN to answer out-of-range beats with SLVERR instead of aliasing.
module axi4_sram_slave
  import axi4_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_AW     = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     s_axi4_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi4_awaddr,
  input  logic [7:0]              s_axi4_awlen,
  input  logic [2:0]              s_axi4_awsize,
  input  logic [1:0]              s_axi4_awburst,
  input  logic                    s_axi4_awvalid,
  output logic                    s_axi4_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi4_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi4_wstrb,
  input  logic                    s_axi4_wlast,
  input  logic                    s_axi4_wvalid,
  output logic                    s_axi4_wready,
  output logic [ID_WIDTH-1:0]     s_axi4_bid,
  output logic [1:0]              s_axi4_bresp,
  output logic                    s_axi4_bvalid,
  input  logic                    s_axi4_bready,
  input  logic [ID_WIDTH-1:0]     s_axi4_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi4_araddr,
  input  logic [7:0]              s_axi4_arlen,
  input  logic [2:0]              s_axi4_arsize,
  input  logic [1:0]              s_axi4_arburst,
  input  logic                    s_axi4_arvalid,
  output logic                    s_axi4_arready,
  output logic [ID_WIDTH-1:0]     s_axi4_rid,
  output logic [DATA_WIDTH-1:0]   s_axi4_rdata,
  output logic [1:0]              s_axi4_rresp,
  output logic                    s_axi4_rlast,
  output logic                    s_axi4_rvalid,
  input  logic                    s_axi4_rready,
  output logic                    ram_en,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [MEM_AW-1:0]       ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  localparam int OFF = $clog2(DATA_WIDTH / 8);

  state_t                state, state_next;
  logic                  last_wr;
  logic                  active;
  logic                  wr_err;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [7:0]            beat_cnt;
  logic                  grant_w, grant_r;
  logic                  aw_hs, ar_hs, w_hs, r_hs;
  logic                  beat_last;
  logic                  oob;
  logic [MEM_AW-1:0]     word_addr;
  logic                  unused_wlast;

  // Burst length comes from AWLEN alone, so WLAST carries no information here.
  assign unused_wlast = s_axi4_wlast;

  assign word_addr = addr_q[MEM_AW+OFF-1:OFF];
  assign beat_last = (beat_cnt == len_q);

  // Round robin on simultaneous requests; active holds off grants until the cycle after reset.
  assign grant_w = active & s_axi4_awvalid & (~s_axi4_arvalid | ~last_wr);
  assign grant_r = active & s_axi4_arvalid & (~s_axi4_awvalid | last_wr);
  assign aw_hs   = (state == IDLE) & grant_w;
  assign ar_hs   = (state == IDLE) & grant_r;
  assign w_hs    = (state == WR_DATA) & s_axi4_wvalid;
  assign r_hs    = (state == RD_RESP) & s_axi4_rready;

`ifdef AXI_SRAM_BOUNDS_CHK_EN
  assign oob = (addr_q >> (MEM_AW + OFF)) != '0;
`else
  assign oob = 1'b0;
`endif

  axi_burst_addr_next #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_next (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (addr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (aw_hs)      state_next = WR_DATA;
        else if (ar_hs) state_next = RD_REQ;
      end
      WR_DATA: if (w_hs && beat_last) state_next = WR_RESP;
      WR_RESP: if (s_axi4_bready) state_next = IDLE;
      RD_REQ:  state_next = RD_RESP;
      RD_RESP: if (r_hs) state_next = beat_last ? IDLE : RD_REQ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      last_wr  <= 1'b0;
      wr_err   <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      beat_cnt <= '0;
    end else begin
      active <= 1'b1;
      if (aw_hs) begin
        id_q     <= s_axi4_awid;
        addr_q   <= s_axi4_awaddr;
        len_q    <= s_axi4_awlen;
        size_q   <= s_axi4_awsize;
        burst_q  <= s_axi4_awburst;
        beat_cnt <= '0;
        last_wr  <= 1'b1;
        wr_err   <= 1'b0;
      end else if (ar_hs) begin
        id_q     <= s_axi4_arid;
        addr_q   <= s_axi4_araddr;
        len_q    <= s_axi4_arlen;
        size_q   <= s_axi4_arsize;
        burst_q  <= s_axi4_arburst;
        beat_cnt <= '0;
        last_wr  <= 1'b0;
      end else if (w_hs) begin
        addr_q   <= addr_nxt;
        beat_cnt <= beat_cnt + 8'd1;
        wr_err   <= wr_err | oob;
      end else if (r_hs && !beat_last) begin
        addr_q   <= addr_nxt;
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    s_axi4_awready = 1'b0;
    s_axi4_arready = 1'b0;
    s_axi4_wready  = 1'b0;
    s_axi4_bvalid  = 1'b0;
    s_axi4_bid     = '0;
    s_axi4_bresp   = RESP_OKAY;
    s_axi4_rvalid  = 1'b0;
    s_axi4_rid     = '0;
    s_axi4_rdata   = '0;
    s_axi4_rresp   = RESP_OKAY;
    s_axi4_rlast   = 1'b0;
    ram_en         = 1'b0;
    ram_we         = '0;
    ram_addr       = '0;
    ram_wdata      = '0;
    case (state)
      IDLE: begin
        s_axi4_awready = grant_w;
        s_axi4_arready = grant_r;
      end
      WR_DATA: begin
        s_axi4_wready = 1'b1;
        ram_en        = s_axi4_wvalid & ~oob;
        ram_we        = (s_axi4_wvalid && !oob) ? s_axi4_wstrb : '0;
        ram_addr      = word_addr;
        ram_wdata     = s_axi4_wdata;
      end
      WR_RESP: begin
        s_axi4_bvalid = 1'b1;
        s_axi4_bid    = id_q;
        s_axi4_bresp  = wr_err ? RESP_SLVERR : RESP_OKAY;
      end
      RD_REQ: begin
        ram_en   = ~oob;
        ram_addr = word_addr;
      end
      RD_RESP: begin
        s_axi4_rvalid = 1'b1;
        s_axi4_rid    = id_q;
        s_axi4_rdata  = oob ? '0 : ram_rdata;
        s_axi4_rresp  = oob ? RESP_SLVERR : RESP_OKAY;
        s_axi4_rlast  = beat_last;
      end
      default: ;
    endcase
  end

endmodule
